// File: rtl/seq_window_checker_pkg.sv
// Shared types and parameter checks for the windowed sequence checker.
package seq_chk_pkg;

  // Largest supported window depth; bounds the pending-attempt vector.
  localparam int MAX_DLY_LIMIT = 32;

  // Registered failure reason: bit0 = timeout, bit1 = antecedent false.
  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_TIMEOUT = 2'b01,
    FC_ANTE    = 2'b10,
    FC_BOTH    = 2'b11
  } fail_code_t;

  // True when the delay window can be built by the checker.
  function automatic bit params_legal(int dly_min, int dly_max);
    return (dly_min >= 0) && (dly_max >= 1) && (dly_max >= dly_min) &&
           (dly_max <= MAX_DLY_LIMIT);
  endfunction

endpackage

// File: rtl/seq_window_checker_if.sv
// Stimulus and result bundle between a monitored design and the checker.
interface seq_window_checker_if #(
  parameter int CNT_W = 16
);
  logic             en_i;
  logic             clr_i;
  logic             a_i;
  logic             b_i;
  logic             pass_o;
  logic             fail_o;
  logic [1:0]       fail_code_o;
  logic             busy_o;
  logic [CNT_W-1:0] pass_cnt_o;
  logic [CNT_W-1:0] fail_cnt_o;

  // Side that samples the protocol and reads verdicts.
  modport master (
    output en_i, clr_i, a_i, b_i,
    input  pass_o, fail_o, fail_code_o, busy_o, pass_cnt_o, fail_cnt_o
  );

  // Checker side.
  modport slave (
    input  en_i, clr_i, a_i, b_i,
    output pass_o, fail_o, fail_code_o, busy_o, pass_cnt_o, fail_cnt_o
  );
endinterface

// File: rtl/seq_window_checker_sat_counter.sv
// Saturating accumulator: adds a small per-cycle increment, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] count
);
  // One spare bit above the wider operand so the sum never wraps.
  localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [SUM_W-1:0] sum;

  // Full-width sum of the current count and this cycle's increment.
  always_comb begin
    sum = SUM_W'(count) + SUM_W'(inc);
  end

  // Clamp the whole increment at all-ones; clear wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (sum > CNT_MAX) begin
      count <= '1;
    end else begin
      count <= sum[CNT_W-1:0];
    end
  end
endmodule

// File: rtl/seq_window_checker.sv
// Checks "a followed by b within [DLY_MIN:DLY_MAX] cycles" with overlapping attempts.
module seq_window_checker
  import seq_chk_pkg::*;
#(
  parameter int DLY_MIN     = 1,
  parameter int DLY_MAX     = 1,
  parameter int IMPLICATION = 0,
  parameter int CNT_W       = 16
) (
  input logic           clk,
  input logic           rst_n,
  seq_window_checker_if.slave bus
);
  // Enough bits to count every pending attempt plus a same-edge start.
  localparam int INC_W = $clog2(DLY_MAX + 2);

  generate
    if (!params_legal(DLY_MIN, DLY_MAX)) begin : g_bad_params
      $error("seq_window_checker: illegal DLY_MIN/DLY_MAX combination");
    end
  endgenerate

  // pend[k] set means an attempt started k edges ago is still waiting for b.
  logic [DLY_MAX:1] pend;
  logic [DLY_MAX:1] pend_next;
  logic [INC_W-1:0] pass_inc;
  logic [INC_W-1:0] fail_inc;
  logic             timeout_hit;
  logic             ante_fail;
  fail_code_t       code_next;

  logic             pass_q;
  logic             fail_q;
  fail_code_t       code_q;
  logic             busy_q;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  // Resolve every outstanding attempt and start a new one for this edge.
  always_comb begin
    pend_next   = '0;
    pass_inc    = '0;
    timeout_hit = 1'b0;
    ante_fail   = 1'b0;
    for (int k = 1; k < DLY_MAX; k++) begin
      if (pend[k]) begin
        if ((k >= DLY_MIN) && bus.b_i) begin
          pass_inc = pass_inc + INC_W'(1);
        end else begin
          pend_next[k+1] = 1'b1;
        end
      end
    end
    // The oldest slot is always inside the window, so it either passes or times out.
    if (pend[DLY_MAX]) begin
      if (bus.b_i) begin
        pass_inc = pass_inc + INC_W'(1);
      end else begin
        timeout_hit = 1'b1;
      end
    end
    if (bus.en_i) begin
      if (bus.a_i) begin
        if ((DLY_MIN == 0) && bus.b_i) begin
          pass_inc = pass_inc + INC_W'(1);
        end else begin
          pend_next[1] = 1'b1;
        end
      end else if (IMPLICATION == 0) begin
        ante_fail = 1'b1;
      end
    end
    fail_inc  = INC_W'(timeout_hit) + INC_W'(ante_fail);
    code_next = fail_code_t'({ante_fail, timeout_hit});
  end

  // Register the pending vector and the per-edge verdict pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      code_q <= FC_NONE;
      busy_q <= 1'b0;
    end else if (bus.clr_i) begin
      pend   <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      code_q <= FC_NONE;
      busy_q <= 1'b0;
    end else begin
      pend   <= pend_next;
      pass_q <= (pass_inc != '0);
      fail_q <= timeout_hit | ante_fail;
      code_q <= code_next;
      busy_q <= |pend_next;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (INC_W)
  ) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr_i),
    .inc   (pass_inc),
    .count (pass_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (INC_W)
  ) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr_i),
    .inc   (fail_inc),
    .count (fail_cnt)
  );

  assign bus.pass_o      = pass_q;
  assign bus.fail_o      = fail_q;
  assign bus.fail_code_o = code_q;
  assign bus.busy_o      = busy_q;
  assign bus.pass_cnt_o  = pass_cnt;
  assign bus.fail_cnt_o  = fail_cnt;
endmodule

// File: tb/tb_seq_window_checker.sv
// Scoreboard bench for seq_window_checker across four window configurations.
module tb_seq_window_checker;

  typedef struct packed {
    logic en;
    logic clr;
    logic a;
    logic b;
  } stim_t;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic [1:0]  code;
    logic        busy;
    logic [15:0] pcnt;
    logic [15:0] fcnt;
  } exp_t;

  localparam int SEL_A = 0;  // DLY 1..1, sequence mode
  localparam int SEL_B = 1;  // DLY 2..4, implication mode
  localparam int SEL_C = 2;  // DLY 0..2, implication mode
  localparam int SEL_D = 3;  // DLY 1..1, sequence mode, 2-bit counters

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  seq_window_checker_if #(.CNT_W(16)) if_a ();
  seq_window_checker_if #(.CNT_W(16)) if_b ();
  seq_window_checker_if #(.CNT_W(16)) if_c ();
  seq_window_checker_if #(.CNT_W(2))  if_d ();

  seq_window_checker #(.DLY_MIN(1), .DLY_MAX(1), .IMPLICATION(0), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  seq_window_checker #(.DLY_MIN(2), .DLY_MAX(4), .IMPLICATION(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  seq_window_checker #(.DLY_MIN(0), .DLY_MAX(2), .IMPLICATION(1), .CNT_W(16)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));
  seq_window_checker #(.DLY_MIN(1), .DLY_MAX(1), .IMPLICATION(0), .CNT_W(2)) u_dut_d (
    .clk(clk), .rst_n(rst_n), .bus(if_d.slave));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t st(input logic en, input logic clr, input logic a, input logic b);
    stim_t s;
    s.en = en; s.clr = clr; s.a = a; s.b = b;
    return s;
  endfunction

  function automatic exp_t ex(input logic pass, input logic fail, input int code,
                              input logic busy, input int pc, input int fc);
    exp_t e;
    e.pass = pass; e.fail = fail; e.code = 2'(code); e.busy = busy;
    e.pcnt = 16'(pc); e.fcnt = 16'(fc);
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("pass=%0b fail=%0b code=%02b busy=%0b pcnt=%0d fcnt=%0d",
                     e.pass, e.fail, e.code, e.busy, e.pcnt, e.fcnt);
  endfunction

  function automatic exp_t observe(input int sel);
    exp_t o;
    o = '0;
    case (sel)
      SEL_A: o = '{if_a.pass_o, if_a.fail_o, if_a.fail_code_o, if_a.busy_o, if_a.pass_cnt_o, if_a.fail_cnt_o};
      SEL_B: o = '{if_b.pass_o, if_b.fail_o, if_b.fail_code_o, if_b.busy_o, if_b.pass_cnt_o, if_b.fail_cnt_o};
      SEL_C: o = '{if_c.pass_o, if_c.fail_o, if_c.fail_code_o, if_c.busy_o, if_c.pass_cnt_o, if_c.fail_cnt_o};
      default: o = '{if_d.pass_o, if_d.fail_o, if_d.fail_code_o, if_d.busy_o,
                     {14'd0, if_d.pass_cnt_o}, {14'd0, if_d.fail_cnt_o}};
    endcase
    return o;
  endfunction

  task automatic drive(input int sel, input stim_t s);
    @(negedge clk);
    case (sel)
      SEL_A: begin if_a.en_i = s.en; if_a.clr_i = s.clr; if_a.a_i = s.a; if_a.b_i = s.b; end
      SEL_B: begin if_b.en_i = s.en; if_b.clr_i = s.clr; if_b.a_i = s.a; if_b.b_i = s.b; end
      SEL_C: begin if_c.en_i = s.en; if_c.clr_i = s.clr; if_c.a_i = s.a; if_c.b_i = s.b; end
      default: begin if_d.en_i = s.en; if_d.clr_i = s.clr; if_d.a_i = s.a; if_d.b_i = s.b; end
    endcase
  endtask

  task automatic test_reset();
    exp_t got;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int sel = 0; sel < 4; sel++) begin
      got = observe(sel);
      checks++;
      if (got !== exp_t'(0)) begin
        failures++;
        $display("[TB] FAIL reset dut%0d got %s want all zero", sel, fmt(got));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_pass();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 0, 0));
    s.push_back(st(0, 0, 0, 1)); e.push_back(ex(1, 0, 0, 0, 1, 0));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 1, 0));
    foreach (s[i]) begin
      drive(SEL_A, s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = observe(SEL_A);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL basic_pass[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_fail_codes();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(1, 0, 0, 0)); e.push_back(ex(0, 1, 2, 0, 1, 1));
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 1, 1));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 1, 1, 0, 1, 2));
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 1, 2));
    s.push_back(st(1, 0, 0, 0)); e.push_back(ex(0, 1, 3, 0, 1, 4));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 1, 4));
    foreach (s[i]) begin
      drive(SEL_A, s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = observe(SEL_A);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL fail_codes[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_overlap();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 0, 0));
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 0, 0));
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 0, 0));
    s.push_back(st(1, 0, 0, 0)); e.push_back(ex(0, 0, 0, 1, 0, 0));
    s.push_back(st(1, 0, 0, 1)); e.push_back(ex(1, 0, 0, 0, 3, 0));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 3, 0));
    foreach (s[i]) begin
      drive(SEL_B, s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = observe(SEL_B);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL overlap[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_timeout();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 3, 0));
    s.push_back(st(1, 0, 0, 1)); e.push_back(ex(0, 0, 0, 1, 3, 0));
    s.push_back(st(1, 0, 0, 0)); e.push_back(ex(0, 0, 0, 1, 3, 0));
    s.push_back(st(1, 0, 0, 0)); e.push_back(ex(0, 0, 0, 1, 3, 0));
    s.push_back(st(1, 0, 0, 0)); e.push_back(ex(0, 1, 1, 0, 3, 1));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 3, 1));
    foreach (s[i]) begin
      drive(SEL_B, s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = observe(SEL_B);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL timeout[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_immediate();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(1, 0, 1, 1)); e.push_back(ex(1, 0, 0, 0, 1, 0));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 1, 0));
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 1, 0));
    s.push_back(st(1, 0, 0, 1)); e.push_back(ex(1, 0, 0, 0, 2, 0));
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 2, 0));
    s.push_back(st(1, 0, 1, 1)); e.push_back(ex(1, 0, 0, 0, 4, 0));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 4, 0));
    foreach (s[i]) begin
      drive(SEL_C, s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = observe(SEL_C);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL immediate[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_saturation();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(1, 0, 0, 0)); e.push_back(ex(0, 1, 2, 0, 0, 1));
    s.push_back(st(1, 0, 0, 0)); e.push_back(ex(0, 1, 2, 0, 0, 2));
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 0, 2));
    s.push_back(st(1, 0, 0, 0)); e.push_back(ex(0, 1, 3, 0, 0, 3));
    s.push_back(st(1, 0, 0, 0)); e.push_back(ex(0, 1, 2, 0, 0, 3));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 0, 3));
    foreach (s[i]) begin
      drive(SEL_D, s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = observe(SEL_D);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL saturation[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_clear();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 0, 3));
    s.push_back(st(1, 1, 0, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
    s.push_back(st(1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 1, 0, 0));
    s.push_back(st(0, 0, 0, 1)); e.push_back(ex(1, 0, 0, 0, 1, 0));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 1, 0));
    foreach (s[i]) begin
      drive(SEL_D, s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = observe(SEL_D);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL clear[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    drive(SEL_B, st(1, 0, 1, 0));
    sb.push_back(ex(0, 0, 0, 1, 3, 1));
    @(posedge clk); #1;
    got  = observe(SEL_B);
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL reset_mid_start got %s want %s", fmt(got), fmt(want));
    end
    drive(SEL_B, st(0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    for (int sel = 0; sel < 4; sel++) begin
      got = observe(sel);
      checks++;
      if (got !== exp_t'(0)) begin
        failures++;
        $display("[TB] FAIL reset_mid_async dut%0d got %s want all zero", sel, fmt(got));
      end
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(SEL_B, s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = observe(SEL_B);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL reset_mid_after[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    checks   = 0;
    failures = 0;
    if_a.en_i = 1'b0; if_a.clr_i = 1'b0; if_a.a_i = 1'b0; if_a.b_i = 1'b0;
    if_b.en_i = 1'b0; if_b.clr_i = 1'b0; if_b.a_i = 1'b0; if_b.b_i = 1'b0;
    if_c.en_i = 1'b0; if_c.clr_i = 1'b0; if_c.a_i = 1'b0; if_c.b_i = 1'b0;
    if_d.en_i = 1'b0; if_d.clr_i = 1'b0; if_d.a_i = 1'b0; if_d.b_i = 1'b0;
    $display("[TB] start");
    test_reset();
    test_basic_pass();
    test_fail_codes();
    test_overlap();
    test_timeout();
    test_immediate();
    test_saturation();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
